// File: rtl/pepe_pkg.sv
// Shared types and constants for the pepe arithmetic tile.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pepe_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 4;

  // Channel-select width; a single-channel build still carries a 1-bit select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pepe_alu.sv
// Add/subtract at WIDTH+1 bits with raw carry/borrow flag and optional clamping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module pepe_alu #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  logic [WIDTH:0] raw;

  // Extended-width sum or difference; the top bit is carry (add) or borrow (sub).
  always_comb begin
    if (sub) raw = {1'b0, op_a} - {1'b0, op_b};
    else     raw = {1'b0, op_a} + {1'b0, op_b};
  end

  // Clamp to the rail on carry/borrow when saturating, otherwise keep the low bits.
  always_comb begin
    ovf    = raw[WIDTH];
    result = raw[WIDTH-1:0];
    if (SATURATE && raw[WIDTH]) result = sub ? '0 : '1;
  end

endmodule

// File: rtl/pepe_accum.sv
// Pipelined ADD/SUB/per-channel ACC/CLR unit with a registered result.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready drops while an undelivered result is held and out_ready is low, or when ena=0.
module pepe_accum
  import pepe_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter bit SATURATE = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  input  logic [1:0]                  mode,
  input  logic [ch_w(CHANNELS)-1:0]   ch_sel,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_ovf
);

  localparam int CW = ch_w(CHANNELS);

  logic [WIDTH-1:0] acc_q [CHANNELS];
  logic [WIDTH-1:0] acc_d [CHANNELS];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept;
  logic             ch_ok;
  logic [WIDTH-1:0] acc_rd;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic             alu_sub, alu_ovf;
  mode_e            op;

  assign op        = mode_e'(mode);
  assign in_ready  = rst_n && ena && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // Decode the channel select; an out-of-range select matches no accumulator.
  always_comb begin
    ch_ok  = 1'b0;
    acc_rd = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == CW'(i)) begin
        ch_ok  = 1'b1;
        acc_rd = acc_q[i];
      end
    end
  end

  // ACC feeds the stored accumulator as the first operand and A as the increment.
  always_comb begin
    alu_a   = (op == MODE_ACC) ? acc_rd : a;
    alu_b   = (op == MODE_ACC) ? a : b;
    alu_sub = (op == MODE_SUB);
  end

  pepe_alu #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_alu (
    .op_a   (alu_a),
    .op_b   (alu_b),
    .sub    (alu_sub),
    .result (alu_res),
    .ovf    (alu_ovf)
  );

  // Next result/accumulator state: load on accept, drain on out_ready, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      unique case (op)
        MODE_ADD, MODE_SUB: begin
          out_data_d = alu_res;
          out_ovf_d  = alu_ovf;
        end
        MODE_ACC: begin
          out_data_d = ch_ok ? alu_res : '0;
          out_ovf_d  = ch_ok ? alu_ovf : 1'b1;
          for (int i = 0; i < CHANNELS; i++) begin
            if (ch_sel == CW'(i)) acc_d[i] = alu_res;
          end
        end
        MODE_CLR: begin
          out_data_d = '0;
          out_ovf_d  = !ch_ok;
          for (int i = 0; i < CHANNELS; i++) begin
            if (ch_sel == CW'(i)) acc_d[i] = '0;
          end
        end
      endcase
    end else if (ena && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any pending result and zeroes every accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '{default: '0};
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
    end
  end

endmodule

// File: tb/tb_pepe_accum.sv
// Bench for pepe_accum: a saturating 4-channel build and a wrapping 3-channel build share stimulus.
// Latency: results checked one cycle after each accept.
// Backpressure: out_ready and ena are driven explicitly and at random.
module tb_pepe_accum;

  logic       clk, rst_n, ena, in_valid, out_ready;
  logic [7:0] a, b;
  logic [1:0] mode, ch_sel;
  logic       rdy_s, vld_s, ovf_s, rdy_w, vld_w, ovf_w;
  logic [7:0] dat_s, dat_w;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: expected output register and accumulators per build.
  bit ev;
  int ed_s, ed_w;
  bit eo_s, eo_w;
  int acc_s [4];
  int acc_w [3];

  pepe_accum #(.WIDTH(8), .CHANNELS(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(rdy_s),
    .a(a), .b(b), .mode(mode), .ch_sel(ch_sel), .out_valid(vld_s),
    .out_ready(out_ready), .out_data(dat_s), .out_ovf(ovf_s)
  );

  pepe_accum #(.WIDTH(8), .CHANNELS(3), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(rdy_w),
    .a(a), .b(b), .mode(mode), .ch_sel(ch_sel), .out_valid(vld_w),
    .out_ready(out_ready), .out_data(dat_w), .out_ovf(ovf_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Arithmetic straight from the operation rules, on plain integers.
  function automatic void calc(input bit sat, input int m, input int av, input int bv,
                               input int accv, input bit chok,
                               output int r, output bit o, output bit wr, output int nacc);
    int raw;
    r = 0; o = 1'b0; wr = 1'b0; nacc = 0;
    case (m)
      0: begin raw = av + bv; o = raw > 255; r = o ? (sat ? 255 : raw - 256) : raw; end
      1: begin raw = av - bv; o = av < bv;   r = o ? (sat ? 0 : raw + 256) : raw; end
      2: begin
        if (!chok) begin r = 0; o = 1'b1; end
        else begin
          raw = accv + av; o = raw > 255; r = o ? (sat ? 255 : raw - 256) : raw;
          wr = 1'b1; nacc = r;
        end
      end
      default: begin
        if (!chok) begin r = 0; o = 1'b1; end
        else begin r = 0; o = 1'b0; wr = 1'b1; nacc = 0; end
      end
    endcase
  endfunction

  function automatic bit exp_ready();
    return rst_n && ena && (!ev || out_ready);
  endfunction

  task automatic model_reset();
    ev = 1'b0; ed_s = 0; ed_w = 0; eo_s = 1'b0; eo_w = 1'b0;
    foreach (acc_s[i]) acc_s[i] = 0;
    foreach (acc_w[i]) acc_w[i] = 0;
  endtask

  task automatic drive(input int v, input int m, input int av, input int bv,
                       input int ch, input bit ordy);
    in_valid = v[0]; mode = 2'(m); a = 8'(av); b = 8'(bv); ch_sel = 2'(ch);
    out_ready = ordy;
    #1;
  endtask

  // Advance one clock edge, updating the reference with whatever the inputs request.
  task automatic tick();
    int r, na;
    bit o, wr;
    int ch;
    ch = int'(ch_sel);
    if (in_valid && exp_ready()) begin
      calc(1'b1, int'(mode), int'(a), int'(b), acc_s[ch], 1'b1, r, o, wr, na);
      ed_s = r; eo_s = o;
      if (wr) acc_s[ch] = na;
      calc(1'b0, int'(mode), int'(a), int'(b), (ch < 3) ? acc_w[ch % 3] : 0, ch < 3,
           r, o, wr, na);
      ed_w = r; eo_w = o;
      if (wr) acc_w[ch] = na;
      ev = 1'b1;
    end else if (ena && out_ready) begin
      ev = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 8'd1; b = 8'd2; mode = 2'd0; ch_sel = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if ({rdy_s, rdy_w} !== 2'b00) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 00", {rdy_s, rdy_w});
    end
    n_checks++;
    if ({vld_s, ovf_s, dat_s} !== 10'd0) begin
      n_fail++; $display("FAIL reset_out_sat: got v=%b o=%b d=%0d want all 0", vld_s, ovf_s, dat_s);
    end
    n_checks++;
    if ({vld_w, ovf_w, dat_w} !== 10'd0) begin
      n_fail++; $display("FAIL reset_out_wrap: got v=%b o=%b d=%0d want all 0", vld_w, ovf_w, dat_w);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    drive(1, 0, 100, 27, 0, 1);
    n_checks++;
    if (rdy_s !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %b want 1", rdy_s); end
    tick();
    n_checks++;
    if ({vld_s, ovf_s, dat_s} !== {1'b1, 1'b0, 8'd127}) begin
      n_fail++; $display("FAIL add_100_27: got v=%b o=%b d=%0d want v=1 o=0 d=127", vld_s, ovf_s, dat_s);
    end
  endtask

  task automatic test_sat_wrap();
    drive(1, 0, 200, 100, 0, 1);
    tick();
    n_checks++;
    if ({vld_s, ovf_s, dat_s} !== {1'b1, 1'b1, 8'd255}) begin
      n_fail++; $display("FAIL sat_add: got v=%b o=%b d=%0d want v=1 o=1 d=255", vld_s, ovf_s, dat_s);
    end
    n_checks++;
    if ({vld_w, ovf_w, dat_w} !== {1'b1, 1'b1, 8'd44}) begin
      n_fail++; $display("FAIL wrap_add: got v=%b o=%b d=%0d want v=1 o=1 d=44", vld_w, ovf_w, dat_w);
    end
    drive(1, 1, 5, 9, 0, 1);
    tick();
    n_checks++;
    if ({vld_s, ovf_s, dat_s} !== {1'b1, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL sat_sub: got v=%b o=%b d=%0d want v=1 o=1 d=0", vld_s, ovf_s, dat_s);
    end
    n_checks++;
    if ({vld_w, ovf_w, dat_w} !== {1'b1, 1'b1, 8'd252}) begin
      n_fail++; $display("FAIL wrap_sub: got v=%b o=%b d=%0d want v=1 o=1 d=252", vld_w, ovf_w, dat_w);
    end
  endtask

  task automatic test_channels();
    for (int k = 1; k <= 3; k++) begin
      drive(1, 2, 10, 0, 0, 1);
      tick();
      n_checks++;
      if ({vld_s, ovf_s, dat_s} !== {1'b1, 1'b0, 8'(10 * k)}) begin
        n_fail++; $display("FAIL acc_ch0_beat%0d: got d=%0d o=%b want d=%0d o=0", k, dat_s, ovf_s, 10 * k);
      end
    end
    drive(1, 2, 1, 0, 1, 1);
    tick();
    n_checks++;
    if ({vld_w, ovf_w, dat_w} !== {1'b1, 1'b0, 8'd1}) begin
      n_fail++; $display("FAIL acc_ch1: got d=%0d o=%b want d=1 o=0", dat_w, ovf_w);
    end
    drive(1, 3, 0, 0, 0, 1);
    tick();
    n_checks++;
    if ({vld_s, ovf_s, dat_s} !== {1'b1, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL clr_ch0: got d=%0d o=%b want d=0 o=0", dat_s, ovf_s);
    end
    drive(1, 2, 4, 0, 0, 1);
    tick();
    n_checks++;
    if ({vld_s, ovf_s, dat_s, vld_w, ovf_w, dat_w} !== {1'b1, 1'b0, 8'd4, 1'b1, 1'b0, 8'd4}) begin
      n_fail++; $display("FAIL acc_after_clr: got sat=%0d wrap=%0d want 4", dat_s, dat_w);
    end
    // Channel 3 exists only in the saturating build; the wrapping build flags it.
    drive(1, 2, 5, 0, 3, 1);
    tick();
    n_checks++;
    if ({ovf_s, dat_s} !== {1'b0, 8'd5}) begin
      n_fail++; $display("FAIL acc_ch3_sat: got d=%0d o=%b want d=5 o=0", dat_s, ovf_s);
    end
    n_checks++;
    if ({vld_w, ovf_w, dat_w} !== {1'b1, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL acc_badch_wrap: got v=%b o=%b d=%0d want v=1 o=1 d=0", vld_w, ovf_w, dat_w);
    end
    drive(1, 3, 0, 0, 3, 1);
    tick();
    n_checks++;
    if ({ovf_w, dat_w} !== {1'b1, 8'd0}) begin
      n_fail++; $display("FAIL clr_badch_wrap: got d=%0d o=%b want d=0 o=1", dat_w, ovf_w);
    end
    drive(1, 2, 0, 0, 1, 1);
    tick();
    n_checks++;
    if (dat_w !== 8'd1) begin
      n_fail++; $display("FAIL ch1_untouched: got %0d want 1", dat_w);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_backpressure();
    drive(1, 0, 3, 4, 0, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0);
      n_checks++;
      if (rdy_s !== 1'b0) begin n_fail++; $display("FAIL bp_ready_%0d: got %b want 0", k, rdy_s); end
      tick();
      n_checks++;
      if ({vld_s, ovf_s, dat_s} !== {1'b1, 1'b0, 8'd7}) begin
        n_fail++; $display("FAIL bp_hold_%0d: got v=%b d=%0d want v=1 d=7", k, vld_s, dat_s);
      end
    end
    drive(1, 1, 50, 8, 0, 1);
    n_checks++;
    if (rdy_s !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", rdy_s); end
    tick();
    n_checks++;
    if ({vld_s, ovf_s, dat_s} !== {1'b1, 1'b0, 8'd42}) begin
      n_fail++; $display("FAIL bp_drain_accept: got v=%b d=%0d want v=1 d=42", vld_s, dat_s);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    n_checks++;
    if ({vld_s, vld_w} !== 2'b00) begin
      n_fail++; $display("FAIL bp_drained: got %b want 00", {vld_s, vld_w});
    end
  endtask

  task automatic test_ena();
    drive(1, 0, 1, 2, 0, 0);
    tick();
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 2, 9, 0, 0, 1);
      n_checks++;
      if ({rdy_s, rdy_w} !== 2'b00) begin
        n_fail++; $display("FAIL ena_ready_%0d: got %b want 00", k, {rdy_s, rdy_w});
      end
      tick();
      n_checks++;
      if ({vld_s, ovf_s, dat_s} !== {1'b1, 1'b0, 8'd3}) begin
        n_fail++; $display("FAIL ena_hold_%0d: got v=%b d=%0d want v=1 d=3", k, vld_s, dat_s);
      end
    end
    ena = 1'b1;
    drive(1, 2, 0, 0, 0, 1);
    tick();
    n_checks++;
    if ({vld_s, dat_s, vld_w, dat_w} !== {1'b1, 8'd4, 1'b1, 8'd4}) begin
      n_fail++; $display("FAIL ena_acc_unchanged: got sat=%0d wrap=%0d want 4", dat_s, dat_w);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 20, 30, 0, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({vld_s, ovf_s, dat_s, vld_w, ovf_w, dat_w} !== 20'd0) begin
      n_fail++; $display("FAIL midreset_clear: got sat v=%b d=%0d wrap v=%b d=%0d want 0", vld_s, dat_s, vld_w, dat_w);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({vld_s, vld_w} !== 2'b00) begin
      n_fail++; $display("FAIL midreset_no_accept: got %b want 00", {vld_s, vld_w});
    end
    rst_n = 1'b1;
    drive(1, 2, 7, 0, 0, 1);
    tick();
    n_checks++;
    if ({vld_s, ovf_s, dat_s, vld_w, dat_w} !== {1'b1, 1'b0, 8'd7, 1'b1, 8'd7}) begin
      n_fail++; $display("FAIL midreset_acc: got sat=%0d wrap=%0d want 7", dat_s, dat_w);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      ena = ($urandom_range(0, 7) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 3) != 0);
      n_checks++;
      if ({rdy_s, rdy_w} !== {2{exp_ready()}}) begin
        n_fail++; $display("FAIL rand_ready_%0d: got %b want %b", k, {rdy_s, rdy_w}, {2{exp_ready()}});
      end
      tick();
      n_checks++;
      if ({vld_s, vld_w} !== {ev, ev}) begin
        n_fail++; $display("FAIL rand_valid_%0d: got %b want %b", k, {vld_s, vld_w}, {ev, ev});
      end
      if (ev) begin
        n_checks++;
        if ({ovf_s, dat_s} !== {eo_s, 8'(ed_s)}) begin
          n_fail++; $display("FAIL rand_sat_%0d: got d=%0d o=%b want d=%0d o=%b", k, dat_s, ovf_s, ed_s, eo_s);
        end
        n_checks++;
        if ({ovf_w, dat_w} !== {eo_w, 8'(ed_w)}) begin
          n_fail++; $display("FAIL rand_wrap_%0d: got d=%0d o=%b want d=%0d o=%b", k, dat_w, ovf_w, ed_w, eo_w);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sat_wrap();
    test_channels();
    test_backpressure();
    test_ena();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pepe_accum.md
# pepe_accum

Parametrised successor to the pin-level adder in the gonsolo_pepe tile. It adds ADD, SUB, per-channel accumulate and clear modes, optional unsigned saturation, and a registered valid/ready output. The block sits between the tile's input pins (operands, mode, channel select) and its output pins. It gives the tile a one-cycle pipelined arithmetic unit with flow control.

## Interface
Parameters:
- WIDTH, 8: operand, result and accumulator width in bits.
- CHANNELS, 4: number of independent accumulators (≥1).
- SATURATE, 1: 1 = clamp on overflow or underflow; 0 = modulo-2^WIDTH wrap.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ena  in  1  tile enable; 0 freezes all state and forces in_ready=0.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned (ignored in ACC/CLR).
- mode  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR.
- ch_sel  in  $clog2(CHANNELS) (min 1)  accumulator channel for ACC/CLR.
- out_valid  out  1  result register holds an undelivered result.
- out_ready  in  1  consumer takes the result.
- out_data  out  WIDTH  result.
- out_ovf  out  1  overflow (ADD/ACC carry) or underflow (SUB borrow) occurred for this result.

## Operation
- Accept: in_valid && in_ready at a rising edge.
- in_ready = ena && (!out_valid || out_ready).
- ADD: r = a + b computed at WIDTH+1 bits; ovf = carry out.
- SUB: r = a − b; ovf = (a < b).
- ACC: r = acc[ch_sel] + a; ovf = carry out. acc[ch_sel] ← r after saturation/wrap.
- CLR: r = 0, ovf = 0, acc[ch_sel] ← 0.
- Saturation with SATURATE=1: overflow gives 2^WIDTH−1; underflow gives 0.
- Wrap with SATURATE=0: low WIDTH bits are kept.
- out_ovf reflects the raw carry/borrow in both SATURATE settings.
- ch_sel ≥ CHANNELS: the beat is accepted; ACC/CLR leave every accumulator unchanged; result 0 and out_ovf=1 (error marker). ADD/SUB ignore ch_sel.
- Only the addressed accumulator changes; ADD/SUB never touch accumulators.
- Output register: loaded on accept. It holds, unchanged, while out_valid && !out_ready.
- out_valid clears on out_ready when there is no new accept.
- Accept and drain in the same cycle: the register reloads and out_valid stays 1.
- ena=0: no accept; out_data, out_valid, out_ovf and accumulators hold; out_ready is ignored (no drain).

## Timing
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_ovf=0, all acc=0. in_ready is 0 during reset and otherwise follows its equation.
- Reset mid-operation: any pending result is discarded; no beat is accepted while rst_n=0.
- Latency: result visible on out_* the cycle after accept (1 cycle).
- Throughput: 1 beat/cycle when out_ready held high.
- Back-to-back ACC on the same channel: the second beat uses the value written by the first (no hazard; the accumulator is updated at the accept edge).
- in_ready is combinational from out_valid, out_ready and ena; no combinational path from in_valid to in_ready.

## Structure
- Package pepe_pkg:
  - mode enum (MODE_ADD, MODE_SUB, MODE_ACC, MODE_CLR).
  - Default WIDTH/CHANNELS constants.
  - Helper for the ch_sel width.
- Sub-module pepe_alu: purely combinational. Inputs: op_a, op_b, sub flag, SATURATE. Outputs: result and ovf. It is used for ADD, SUB and ACC.
- Top pepe_accum holds the accumulator array, the output register and the handshake.

## Test plan
- Reset, then ADD a=8'd100, b=8'd27 with out_ready=1 → next cycle out_valid=1, out_data=127, out_ovf=0.
- SATURATE=1:
  - ADD 200+100 → out_data=255, out_ovf=1.
  - SUB 5−9 → out_data=0, out_ovf=1.
- SATURATE=0: ADD 200+100 → 44, ovf=1; SUB 5−9 → 252, ovf=1.
- Channel isolation:
  - ACC ch0 a=10 three beats back-to-back → results 10, 20, 30.
  - ACC ch1 a=1 → 1.
  - CLR ch0, then ACC ch0 a=4 → 4.
- Backpressure:
  - Hold out_ready=0 after one accept → in_ready=0 and out_data stable for 5 cycles.
  - Raise out_ready with in_valid=1 → drain and accept in the same cycle; out_valid stays 1.
- ena and reset:
  - ena=0 with in_valid=1 for 3 cycles → no accept, no accumulator change.
  - Assert rst_n=0 while out_valid=1 → out_valid=0, out_data=0 immediately; subsequent ACC ch0 a=7 → 7.
